ram_dp_be: RTL and testbench
============================

RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 7, address bits; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter OUT_REG, default 0; 1 adds an output register stage.
REQ-004 Parameter RDW_MODE, default 0; 0 = read-old, 1 = read-new on a same-address read/write.
REQ-005 clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  ADDR_WIDTH  write address.
REQ-009 d  input  DATA_WIDTH  write data.
REQ-010 be  input  DATA_WIDTH/8  byte enables; bit i qualifies d[8i+7:8i].
REQ-011 re  input  1  read enable.
REQ-012 raddr  input  ADDR_WIDTH  read address.
REQ-013 q  output  DATA_WIDTH  read data.
REQ-014 q_valid  output  1  high for exactly the cycle in which q carries the data for an accepted read.
REQ-015 ready  output  1  high when the block accepts we/re.

Function
REQ-016 Write: on a rising edge with we=1 and ready=1, bytes of mem[waddr] with be[i]=1 SHALL take d; bytes with be[i]=0 SHALL be unchanged; we with be=0 SHALL change nothing.
REQ-017 Read: re=1 with ready=1 at edge N SHALL present mem[raddr] on q with q_valid=1 after edge N+1+OUT_REG.
REQ-018 Back-to-back reads SHALL be accepted every cycle, with one q_valid per read, in issue order.
REQ-019 q SHALL hold its last value when q_valid=0.
REQ-020 Same-address read and write in one cycle: RDW_MODE=0 SHALL return the pre-write word; RDW_MODE=1 SHALL return the post-write word, byte-merged per be.
REQ-021 Different-address read and write in one cycle SHALL both complete with no interaction.
REQ-022 we/re SHALL be ignored while ready=0; no memory change and no q_valid.
REQ-023 The control FSM SHALL have states CLEAR and RUN; ready=1 only in RUN.
REQ-024 In CLEAR, an ADDR_WIDTH-bit counter SHALL write all-zero words to addresses 0..2**ADDR_WIDTH-1, one per cycle, ascending.
REQ-025 After the write to the last address, the FSM SHALL move to RUN and ready SHALL rise on the next cycle; the counter SHALL NOT wrap back into CLEAR.
REQ-026 The clear SHALL take exactly 2**ADDR_WIDTH cycles from the first clk edge after rst_n deasserts.

Reset
REQ-027 rst_n=0 SHALL asynchronously force q=0, q_valid=0, the read pipeline valid bits to 0, the clear counter to 0 and ready=0.
REQ-028 Memory contents SHALL NOT be reset by rst_n directly.
REQ-029 rst_n asserted mid-clear SHALL restart the clear from address 0.
REQ-030 rst_n asserted with reads in flight SHALL discard them; no q_valid after release.

Configuration
REQ-031 Macro RAM_DP_BE_CLEAR_EN defined: the FSM SHALL enter CLEAR after reset, per REQ-024 to REQ-026.
REQ-032 Macro RAM_DP_BE_CLEAR_EN undefined: the clear logic SHALL be absent; the FSM SHALL enter RUN directly; ready=1 from the first edge after reset release; memory contents undefined until written.

Verification
REQ-033 CLEAR_EN, defaults: release rst_n -> ready=0 for 128 cycles then 1; reading addresses 0, 64, 127 -> q=0x00000000.
REQ-034 Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101 -> read addr 5 returns 0xDE22BE44.
REQ-035 OUT_REG=0 and OUT_REG=1: read issued at edge N -> q_valid at edge N+1 and N+2 respectively; 4 consecutive reads -> 4 consecutive q_valid pulses.
REQ-036 Addr 9 holds 0xAAAAAAAA; same-cycle write 0x55555555 be=4'b1111 and read of addr 9 -> RDW_MODE=0 returns 0xAAAAAAAA, RDW_MODE=1 returns 0x55555555.
REQ-037 Assert rst_n at clear address 40 and release -> ready stays 0 for a full 128 cycles; a read of addr 60 issued during the clear -> no q_valid.
REQ-038 RAM_DP_BE_CLEAR_EN undefined: ready=1 on the first edge after release; write then read addr 3 -> the written value.

Source files
------------

// File: rtl/ram_dp_be.sv
// Dual-port (1W/1R) byte-enable RAM with a start-up clear sequencer and optional output register.
// Latency: a read accepted at edge N shows q/q_valid after edge N+1+OUT_REG; writes land at edge N.
// Backpressure: ready=0 during reset and while clearing; we/re are ignored then. Clear: RAM_DP_BE_CLEAR_EN.
module ram_dp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   d,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  output logic                    ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  // Stage 0 captures the array word, stage 1 is the q register, stage 2 the optional extra one.
  localparam int NSTG  = 2 + OUT_REG;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [NSTG-1:0]       vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [NSTG];
  logic [DATA_WIDTH-1:0] dat_d [NSTG];

`ifdef RAM_DP_BE_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
`endif

  assign ready  = (state_q == ST_RUN);
  assign wr_acc = we & ready;
  assign rd_acc = re & ready;

  // Control FSM next state and the single write-port mux (clear engine vs. user writes).
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = d;
    mem_be    = be;
`ifdef RAM_DP_BE_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef RAM_DP_BE_CLEAR_EN
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = '0;
        mem_be    = '1;
        if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
          // Last word written: counter parks here, never wraps back into CLEAR.
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        mem_we = wr_acc;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // FSM state and clear counter; reset parks in CLEAR so ready is low while rst_n is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
`ifdef RAM_DP_BE_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef RAM_DP_BE_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // Byte-masked array write; contents deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we && mem_be[i]) begin
        mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Read word; in read-new mode a colliding write is merged byte by byte.
  always_comb begin
    rd_word = mem[raddr];
    if ((RDW_MODE != 0) && wr_acc && (waddr == raddr)) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          rd_word[8*i +: 8] = d[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline: each stage loads only when the previous one is valid, so q holds otherwise.
  always_comb begin
    vld_d    = {vld_q[NSTG-2:0], rd_acc};
    dat_d[0] = rd_acc ? rd_word : dat_q[0];
    for (int s = 1; s < NSTG; s++) begin
      dat_d[s] = vld_q[s-1] ? dat_q[s-1] : dat_q[s];
    end
  end

  // Read pipeline registers; reset drops any in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < NSTG; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < NSTG; s++) begin
        dat_q[s] <= dat_d[s];
      end
    end
  end

  assign q       = dat_q[NSTG-1];
  assign q_valid = vld_q[NSTG-1];

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench for ram_dp_be: two instances (OUT_REG=0/RDW_MODE=0 and OUT_REG=1/RDW_MODE=1)
// share stimulus; reads push expected data plus due cycle, negedge monitors pop and compare.
module tb_ram_dp_be;

`ifdef RAM_DP_BE_CLEAR_EN
  localparam bit CLR     = 1'b1;
  localparam int RDY_LAT = 128;
`else
  localparam bit CLR     = 1'b0;
  localparam int RDY_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [6:0]  waddr = '0;
  logic [6:0]  raddr = '0;
  logic [31:0] d = '0;
  logic [3:0]  be = '0;

  logic [31:0] q0, q1;
  logic        qv0, qv1, rdy0, rdy1;

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .OUT_REG(0), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .d(d), .be(be),
    .re(re), .raddr(raddr), .q(q0), .q_valid(qv0), .ready(rdy0)
  );

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .OUT_REG(1), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .d(d), .be(be),
    .re(re), .raddr(raddr), .q(q1), .q_valid(qv1), .ready(rdy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-instance output monitor, called at every negedge.
  task automatic mon(input int id, input logic v, input logic [31:0] qd);
    exp_t        e;
    logic [31:0] last;
    int          have;
    last = (id == 0) ? last0 : last1;
    have = (id == 0) ? sb0.size() : sb1.size();
    if (!rst_n) begin
      chk($sformatf("u%0d q_valid in reset", id), {31'b0, v}, 32'd0);
      chk($sformatf("u%0d q in reset", id), qd, 32'd0);
      last = '0;
    end else if (v) begin
      if (have == 0) begin
        chk($sformatf("u%0d unexpected q_valid", id), 32'd1, 32'd0);
      end else begin
        e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
        chk($sformatf("u%0d q data", id), qd, e.data);
        chk($sformatf("u%0d q_valid cycle", id), cyc, e.due);
        last = e.data;
      end
    end else begin
      chk($sformatf("u%0d q hold", id), qd, last);
      if (have > 0) begin
        e = (id == 0) ? sb0[0] : sb1[0];
        if (e.due < cyc) begin
          chk($sformatf("u%0d missing q_valid", id), cyc, e.due);
          if (id == 0) void'(sb0.pop_front());
          else         void'(sb1.pop_front());
        end
      end
    end
    if (id == 0) last0 = last;
    else         last1 = last;
  endtask

  always @(negedge clk) begin
    mon(0, qv0, q0);
    mon(1, qv1, q1);
  end

  // One cycle of stimulus, driven 1ns after negedge; e0/e1 are the per-instance read expectations.
  task automatic step(input bit w, input logic [6:0] wa, input logic [31:0] wd, input logic [3:0] wb,
                      input bit r, input logic [6:0] ra, input logic [31:0] e0, input logic [31:0] e1);
    @(negedge clk);
    #1;
    we = w; waddr = wa; d = wd; be = wb;
    re = r; raddr = ra;
    if (r) begin
      sb0.push_back('{e0, cyc + 2});
      sb1.push_back('{e1, cyc + 3});
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] wd, input logic [3:0] wb);
    step(1'b1, a, wd, wb, 1'b0, 7'd0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] e);
    step(1'b0, 7'd0, 32'd0, 4'd0, 1'b1, a, e, e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 32'd0, 4'd0, 1'b0, 7'd0, 32'd0, 32'd0);
  endtask

  // Release reset while holding a read of addr 60 (must be ignored), then count edges until ready.
  task automatic release_and_measure(input string name);
    int k;
    @(negedge clk);
    #1;
    rst_n = 1'b1; we = 1'b0; be = '0; re = 1'b1; raddr = 7'd60;
    k = 0;
    while (k < 1000) begin
      @(negedge clk);
      k++;
      if (rdy0 || rdy1) break;
    end
    #1;
    re = 1'b0;
    chk({name, " u0 ready latency"}, k, RDY_LAT);
    chk({name, " u1 ready agrees"}, {31'b0, rdy1}, {31'b0, rdy0});
  endtask

  task automatic assert_reset(input int hold);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("ready in reset", {30'b0, rdy1, rdy0}, 32'd0);
    release_and_measure("first release");

    if (CLR) begin
      rd(7'd0,   32'h0000_0000);
      rd(7'd64,  32'h0000_0000);
      rd(7'd127, 32'h0000_0000);
    end

    // Byte-enable merge.
    wr(7'd5, 32'hDEAD_BEEF, 4'b1111);
    wr(7'd5, 32'h1122_3344, 4'b0101);
    rd(7'd5, 32'hDE22_BE44);

    // Same-address collision, full and partial byte enables.
    wr(7'd9, 32'hAAAA_AAAA, 4'b1111);
    step(1'b1, 7'd9, 32'h5555_5555, 4'b1111, 1'b1, 7'd9, 32'hAAAA_AAAA, 32'h5555_5555);
    rd(7'd9, 32'h5555_5555);
    wr(7'd10, 32'h0102_0304, 4'b1111);
    step(1'b1, 7'd10, 32'hA0B0_C0D0, 4'b1001, 1'b1, 7'd10, 32'h0102_0304, 32'hA002_03D0);

    // Different addresses in the same cycle; write with no byte enables.
    step(1'b1, 7'd11, 32'h1234_5678, 4'b1111, 1'b1, 7'd5, 32'hDE22_BE44, 32'hDE22_BE44);
    wr(7'd5, 32'hFFFF_FFFF, 4'b0000);

    // Four back-to-back reads.
    rd(7'd5,  32'hDE22_BE44);
    rd(7'd9,  32'h5555_5555);
    rd(7'd10, 32'hA002_03D0);
    rd(7'd11, 32'h1234_5678);

    wr(7'd3, 32'hCAFE_F00D, 4'b1111);
    rd(7'd3, 32'hCAFE_F00D);
    nop(6);

    // Read in flight, then reset with a write to addr 3 held; both must vanish.
    step(1'b0, 7'd0, 32'd0, 4'd0, 1'b0, 7'd0, 32'd0, 32'd0);
    #0;
    re = 1'b1; raddr = 7'd3;
    @(negedge clk);
    #1;
    rst_n = 1'b0; re = 1'b0;
    we = 1'b1; waddr = 7'd3; d = 32'h0; be = 4'b1111;
    repeat (3) @(negedge clk);
    release_and_measure("second release");
    rd(7'd3, CLR ? 32'h0000_0000 : 32'hCAFE_F00D);
    nop(4);

    if (CLR) begin
      // Interrupt the clear at address 40; it must restart from 0 and run the full length.
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      release_and_measure("pre-abort release");
      wr(7'd60, 32'h6060_6060, 4'b1111);
      assert_reset(2);
      @(negedge clk);
      #1;
      rst_n = 1'b1; re = 1'b0; we = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      release_and_measure("mid-clear abort");
      rd(7'd60,  32'h0000_0000);
      rd(7'd127, 32'h0000_0000);
    end

    nop(8);
    chk("u0 scoreboard drained", sb0.size(), 32'd0);
    chk("u1 scoreboard drained", sb1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
